// File: rtl/rx_stat_counters.sv
// Bank of wide receive-statistics counters with sticky overflow flags and an atomic
// two-beat (low/high) read port, optionally clearing the counter as its read is accepted.
module rx_stat_counters #(
  parameter int unsigned CNT_WIDTH = 48,
  parameter bit          CLR_ON_RD = 1'b0,
  parameter int unsigned NUM_CNT   = 18
) (
  input  logic               rxclk,
  input  logic               reset,
  input  logic [NUM_CNT-1:0] stat_inc_i,
  input  logic [3:0]         rx_byte_cnt_i,
  input  logic               clear_all_i,
  input  logic               rd_req_i,
  input  logic [4:0]         rd_addr_i,
  output logic               rd_busy_o,
  output logic               rd_valid_o,
  output logic               rd_last_o,
  output logic               rd_err_o,
  output logic [31:0]        rd_data_o,
  output logic [NUM_CNT-1:0] ovf_vec_o
);

  localparam int RsvIdx  = 13;
  localparam int ByteIdx = int'(NUM_CNT) - 1;
  localparam int HiW     = int'(CNT_WIDTH) - 32;

  typedef enum logic [1:0] {StIdle, StBeatLo, StBeatHi} rd_state_e;

  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0]                ovf_q, ovf_d;

  rd_state_e       state_q;
  logic [HiW-1:0]  snap_hi_q;
  logic            rd_valid_q, rd_last_q, rd_err_q;
  logic [31:0]     rd_data_q;

  logic                 rd_acc, addr_err, clr_rd;
  logic [CNT_WIDTH-1:0] sel_cnt, inc_w, base_w;
  logic [CNT_WIDTH:0]   sum_w;

  assign rd_acc   = rd_req_i && (state_q == StIdle);
  assign addr_err = (rd_addr_i >= 5'(NUM_CNT)) || (rd_addr_i == 5'(RsvIdx));

  // Pre-edge value of the addressed counter; error addresses snapshot as zero.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      if (int'(rd_addr_i) == i && i != RsvIdx) begin
        sel_cnt = cnt_q[i];
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    inc_w  = '0;
    base_w = '0;
    sum_w  = '0;
    clr_rd = 1'b0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      inc_w = '0;
      if (i == ByteIdx) begin
        if (stat_inc_i[i]) begin
          inc_w = {{(CNT_WIDTH-4){1'b0}}, rx_byte_cnt_i};
        end
      end else if (i != RsvIdx) begin
        inc_w = {{(CNT_WIDTH-1){1'b0}}, stat_inc_i[i]};
      end
      // Clear-on-read zeroes the base, so the same-edge increment still lands.
      clr_rd   = CLR_ON_RD && rd_acc && (int'(rd_addr_i) == i);
      base_w   = clr_rd ? '0 : cnt_q[i];
      sum_w    = {1'b0, base_w} + {1'b0, inc_w};
      cnt_d[i] = sum_w[CNT_WIDTH-1:0];
      ovf_d[i] = (ovf_q[i] && !clr_rd) || sum_w[CNT_WIDTH];
      if (clear_all_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      snap_hi_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_acc) begin
            state_q    <= StBeatLo;
            snap_hi_q  <= sel_cnt[CNT_WIDTH-1:32];
            rd_valid_q <= 1'b1;
            rd_last_q  <= 1'b0;
            rd_err_q   <= addr_err;
            rd_data_q  <= sel_cnt[31:0];
          end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
          end
        end
        StBeatLo: begin
          state_q    <= StBeatHi;
          rd_valid_q <= 1'b1;
          rd_last_q  <= 1'b1;
          rd_data_q  <= 32'(snap_hi_q);
        end
        StBeatHi: begin
          state_q    <= StIdle;
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          rd_err_q   <= 1'b0;
          rd_data_q  <= '0;
        end
        default: begin
          state_q    <= StIdle;
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          rd_err_q   <= 1'b0;
          rd_data_q  <= '0;
        end
      endcase
    end
  end

  assign rd_busy_o  = (state_q != StIdle);
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign rd_err_o   = rd_err_q;
  assign rd_data_o  = rd_data_q;
  assign ovf_vec_o  = ovf_q;

endmodule

// File: tb/tb_rx_stat_counters.sv
// Bench for rx_stat_counters: two instances (plain and clear-on-read) share stimulus and
// are checked every cycle against a cycle model and a per-beat scoreboard queue.
module tb_rx_stat_counters;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] stat_inc = '0;
  logic [3:0]  rx_byte_cnt = '0;
  logic        clear_all = 1'b0;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_addr = '0;

  logic        busy0, valid0, last0, err0, busy1, valid1, last1, err1;
  logic [31:0] data0, data1;
  logic [17:0] ovf0, ovf1;

  always #5 rxclk = ~rxclk;

  rx_stat_counters #(.CNT_WIDTH(48), .CLR_ON_RD(1'b0), .NUM_CNT(18)) dut0 (
    .rxclk(rxclk), .reset(reset), .stat_inc_i(stat_inc), .rx_byte_cnt_i(rx_byte_cnt),
    .clear_all_i(clear_all), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_busy_o(busy0),
    .rd_valid_o(valid0), .rd_last_o(last0), .rd_err_o(err0), .rd_data_o(data0),
    .ovf_vec_o(ovf0)
  );

  rx_stat_counters #(.CNT_WIDTH(48), .CLR_ON_RD(1'b1), .NUM_CNT(18)) dut1 (
    .rxclk(rxclk), .reset(reset), .stat_inc_i(stat_inc), .rx_byte_cnt_i(rx_byte_cnt),
    .clear_all_i(clear_all), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_busy_o(busy1),
    .rd_valid_o(valid1), .rd_last_o(last1), .rd_err_o(err1), .rd_data_o(data1),
    .ovf_vec_o(ovf1)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
    int          cyc;
  } beat_t;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [47:0] m0[18];
  logic [47:0] m1[18];
  logic [17:0] mo0, mo1;
  logic [17:0][47:0] pre;
  int          bst, cyc, n_tests, n_fail;

  task automatic model_reset();
    for (int i = 0; i < 18; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    mo0 = '0;
    mo1 = '0;
    bst = 0;
    q0.delete();
    q1.delete();
  endtask

  // Applies one rxclk edge of the specified behaviour to both counter banks.
  task automatic model_step();
    logic        acc, err, clr;
    logic [47:0] v0, v1, inc;
    logic [48:0] s;
    acc = rd_req && (bst == 0);
    if (acc) begin
      err = (rd_addr >= 5'd18) || (rd_addr == 5'd13);
      v0  = '0;
      v1  = '0;
      if (!err) begin
        v0 = m0[int'(rd_addr)];
        v1 = m1[int'(rd_addr)];
      end
      q0.push_back('{v0[31:0], 1'b0, err, cyc + 1});
      q0.push_back('{{16'h0, v0[47:32]}, 1'b1, err, cyc + 2});
      q1.push_back('{v1[31:0], 1'b0, err, cyc + 1});
      q1.push_back('{{16'h0, v1[47:32]}, 1'b1, err, cyc + 2});
    end
    for (int i = 0; i < 18; i++) begin
      inc = '0;
      if (i == 17) begin
        if (stat_inc[17]) inc = {44'h0, rx_byte_cnt};
      end else if (i != 13) begin
        inc = {47'h0, stat_inc[i]};
      end
      s = {1'b0, m0[i]} + {1'b0, inc};
      if (clear_all) begin
        m0[i] = '0; mo0[i] = 1'b0;
      end else begin
        m0[i] = s[47:0]; mo0[i] = mo0[i] | s[48];
      end
      clr = acc && (int'(rd_addr) == i);
      s = {1'b0, (clr ? 48'h0 : m1[i])} + {1'b0, inc};
      if (clear_all) begin
        m1[i] = '0; mo1[i] = 1'b0;
      end else begin
        m1[i] = s[47:0]; mo1[i] = (mo1[i] & ~clr) | s[48];
      end
    end
    bst = acc ? 1 : ((bst == 1) ? 2 : 0);
  endtask

  // Advance one cycle, then check both instances against the model and scoreboard.
  task automatic tick();
    beat_t e;
    @(posedge rxclk);
    if (!reset) model_step();
    cyc++;
    @(negedge rxclk);
    n_tests++;
    if (q0.size() != 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      if (valid0 !== 1'b1 || data0 !== e.data || last0 !== e.last || err0 !== e.err) begin
        n_fail++;
        $display("FAIL sb0_beat cyc=%0d: got v=%b d=%h l=%b e=%b, exp v=1 d=%h l=%b e=%b",
                 cyc, valid0, data0, last0, err0, e.data, e.last, e.err);
      end
    end else if ({valid0, last0, err0} !== 3'b000 || data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL sb0_idle cyc=%0d: got v=%b d=%h l=%b e=%b, exp all 0",
               cyc, valid0, data0, last0, err0);
    end
    n_tests++;
    if (q1.size() != 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      if (valid1 !== 1'b1 || data1 !== e.data || last1 !== e.last || err1 !== e.err) begin
        n_fail++;
        $display("FAIL sb1_beat cyc=%0d: got v=%b d=%h l=%b e=%b, exp v=1 d=%h l=%b e=%b",
                 cyc, valid1, data1, last1, err1, e.data, e.last, e.err);
      end
    end else if ({valid1, last1, err1} !== 3'b000 || data1 !== 32'h0) begin
      n_fail++;
      $display("FAIL sb1_idle cyc=%0d: got v=%b d=%h l=%b e=%b, exp all 0",
               cyc, valid1, data1, last1, err1);
    end
    n_tests++;
    if (ovf0 !== mo0 || ovf1 !== mo1 || busy0 !== (bst != 0) || busy1 !== (bst != 0)) begin
      n_fail++;
      $display("FAIL flags cyc=%0d: got ovf0=%h ovf1=%h busy=%b%b, exp ovf0=%h ovf1=%h busy=%b",
               cyc, ovf0, ovf1, busy0, busy1, mo0, mo1, (bst != 0));
    end
  endtask

  task automatic do_read(input logic [4:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    cyc = 0;
    tick();
    tick();
    n_tests++;
    if (data0 !== 32'h0 || ovf0 !== 18'h0 || ovf1 !== 18'h0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got d=%h ovf0=%h ovf1=%h busy=%b, exp 0", data0, ovf0, ovf1,
               busy0);
    end
    reset = 1'b0;
  endtask

  task automatic test_count();
    stat_inc = 18'h1;
    repeat (5) tick();
    stat_inc = '0;
    do_read(5'd0);
    n_tests++;
    if (valid0 !== 1'b1 || data0 !== 32'd5 || last0 !== 1'b0 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL count_lo: got v=%b d=%0d l=%b e=%b, exp v=1 d=5 l=0 e=0",
               valid0, data0, last0, err0);
    end
    tick();
    n_tests++;
    if (valid0 !== 1'b1 || data0 !== 32'd0 || last0 !== 1'b1) begin
      n_fail++;
      $display("FAIL count_hi: got v=%b d=%0d l=%b, exp v=1 d=0 l=1", valid0, data0, last0);
    end
    tick();
    n_tests++;
    if (valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL count_done: got v=%b, exp 0", valid0);
    end
  endtask

  task automatic test_byte_count();
    stat_inc    = 18'h20000;
    rx_byte_cnt = 4'd8;
    repeat (10) tick();
    rx_byte_cnt = 4'd3;
    tick();
    stat_inc    = '0;
    rx_byte_cnt = 4'd15;
    tick();
    rx_byte_cnt = '0;
    do_read(5'd17);
    n_tests++;
    if (data0 !== 32'd83) begin
      n_fail++;
      $display("FAIL byte_count: got %0d, exp 83", data0);
    end
    tick();
    tick();
    stat_inc    = 18'h20000;
    rx_byte_cnt = 4'd12;
    tick();
    stat_inc    = '0;
    rx_byte_cnt = '0;
    do_read(5'd17);
    n_tests++;
    if (data0 !== 32'd95 || data1 !== 32'd12) begin
      n_fail++;
      $display("FAIL byte_unclamped: got %0d/%0d, exp 95/12", data0, data1);
    end
    tick();
    tick();
  endtask

  task automatic test_overflow();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    pre    = '0;
    pre[5] = '1;
    force dut0.cnt_q = pre;
    force dut1.cnt_q = pre;
    #1;
    release dut0.cnt_q;
    release dut1.cnt_q;
    m0[5] = '1;
    m1[5] = '1;
    stat_inc = 18'h20;
    tick();
    stat_inc = '0;
    n_tests++;
    if (ovf0[5] !== 1'b1 || ovf1[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b/%b, exp 1/1", ovf0[5], ovf1[5]);
    end
    do_read(5'd5);
    n_tests++;
    if (data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL ovf_wrap: got %h, exp 0", data0);
    end
    tick();
    tick();
    n_tests++;
    if (ovf0[5] !== 1'b1 || ovf1[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_after_read: got %b/%b, exp 1/0", ovf0[5], ovf1[5]);
    end
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    n_tests++;
    if (ovf0 !== 18'h0) begin
      n_fail++;
      $display("FAIL ovf_clear_all: got %h, exp 0", ovf0);
    end
  endtask

  task automatic test_clr_on_rd();
    stat_inc = 18'h4;
    repeat (7) tick();
    do_read(5'd2);
    stat_inc = '0;
    n_tests++;
    if (data1 !== 32'd7 || data0 !== 32'd7) begin
      n_fail++;
      $display("FAIL clr_snap: got %0d/%0d, exp 7/7", data0, data1);
    end
    tick();
    tick();
    do_read(5'd2);
    n_tests++;
    if (data1 !== 32'd1 || data0 !== 32'd8) begin
      n_fail++;
      $display("FAIL clr_after: got %0d/%0d, exp 8/1", data0, data1);
    end
    tick();
    tick();
  endtask

  task automatic test_err_reads();
    logic [4:0] addrs [2];
    addrs[0] = 5'd13;
    addrs[1] = 5'd20;
    stat_inc = 18'h2000;
    tick();
    stat_inc = '0;
    foreach (addrs[k]) begin
      do_read(addrs[k]);
      n_tests++;
      if (valid0 !== 1'b1 || data0 !== 32'h0 || err0 !== 1'b1) begin
        n_fail++;
        $display("FAIL err_lo a=%0d: got v=%b d=%h e=%b, exp v=1 d=0 e=1",
                 addrs[k], valid0, data0, err0);
      end
      do_read(5'd0);
      n_tests++;
      if (last0 !== 1'b1 || data0 !== 32'h0 || err0 !== 1'b1) begin
        n_fail++;
        $display("FAIL err_hi a=%0d: got l=%b d=%h e=%b, exp l=1 d=0 e=1",
                 addrs[k], last0, data0, err0);
      end
      tick();
      n_tests++;
      if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
        n_fail++;
        $display("FAIL err_no_third a=%0d: got v=%b/%b, exp 0/0", addrs[k], valid0, valid1);
      end
    end
  endtask

  task automatic test_clear_priority();
    stat_inc  = 18'h8;
    clear_all = 1'b1;
    tick();
    stat_inc  = '0;
    clear_all = 1'b0;
    do_read(5'd3);
    n_tests++;
    if (data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_priority: got %0d, exp 0", data0);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    stat_inc = 18'h2;
    repeat (4) tick();
    stat_inc = '0;
    do_read(5'd1);
    n_tests++;
    if (valid0 !== 1'b1 || data0 !== 32'd4) begin
      n_fail++;
      $display("FAIL abort_pre: got v=%b d=%0d, exp v=1 d=4", valid0, data0);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || last0 !== 1'b0 || data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL abort: got v=%b busy=%b l=%b d=%h, exp 0", valid0, busy0, last0, data0);
    end
    model_reset();
    tick();
    reset = 1'b0;
    do_read(5'd1);
    n_tests++;
    if (data0 !== 32'h0 || valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_cleared: got v=%b d=%0d, exp v=1 d=0", valid0, data0);
    end
    tick();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_count();
    test_byte_count();
    test_overflow();
    test_clr_on_rd();
    test_err_reads();
    test_clear_priority();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
